// File: rtl/delay_ctrl_if.sv
// ============================================================================
//  Module      : delay_ctrl_if
//  Description : Handshake/data bundle for delay_ctrl. The master side drives
//                the sample stream and configuration requests. The slave side
//                (delay_ctrl) returns the selected tap and controller status.
//  Signals     : ena, data, flush, cfg_delay, cfg_valid    (master -> slave)
//                cfg_ready, cfg_err, delay, out_valid,
//                cur_delay, busy                            (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface delay_ctrl_if #(
    parameter int WIDTH     = 16,
    parameter int MAX_DELAY = 8
);
    localparam int DW = $clog2(MAX_DELAY + 1);

    logic             ena;
    logic [WIDTH-1:0] data;
    logic             flush;
    logic [DW-1:0]    cfg_delay;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_err;
    logic [WIDTH-1:0] delay;
    logic             out_valid;
    logic [DW-1:0]    cur_delay;
    logic             busy;

    modport master (
        output ena, data, flush, cfg_delay, cfg_valid,
        input  cfg_ready, cfg_err, delay, out_valid, cur_delay, busy
    );

    modport slave (
        input  ena, data, flush, cfg_delay, cfg_valid,
        output cfg_ready, cfg_err, delay, out_valid, cur_delay, busy
    );
endinterface

`default_nettype wire

// File: rtl/delay_ctrl.sv
// ============================================================================
//  Module      : delay_ctrl
//  Description : Runtime-programmable register delay line. A MAX_DELAY-deep
//                chain shifts on ena. The active tap is chosen by cur_delay,
//                which is changed through a valid/ready configuration
//                handshake. A fill counter and a hold counter make sure that
//                out_valid only ever flags genuine, non-repeated samples.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                bus (slave)   - sample stream, config handshake, status
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_ctrl #(
    parameter int WIDTH      = 16,
    parameter int MAX_DELAY  = 8,
    parameter int INIT_DELAY = 0
) (
    input  wire logic   clk,
    input  wire logic   rst,
    delay_ctrl_if.slave bus
);
    localparam int DW = $clog2(MAX_DELAY + 1);

    generate
        if (WIDTH < 1) begin : g_chk_width
            $error("delay_ctrl: WIDTH must be >= 1");
        end
        if (MAX_DELAY < 1) begin : g_chk_max
            $error("delay_ctrl: MAX_DELAY must be >= 1");
        end
        if (INIT_DELAY < 0 || INIT_DELAY > MAX_DELAY) begin : g_chk_init
            $error("delay_ctrl: INIT_DELAY must be within 0..MAX_DELAY");
        end
    endgenerate

    localparam logic [DW-1:0] c_max_delay  = DW'(MAX_DELAY);
    localparam logic [DW-1:0] c_init_delay = DW'(INIT_DELAY);

    // Controller states, priority HOLD > FILL > RUN
    localparam logic [1:0] c_st_run  = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;
    localparam logic [1:0] c_st_init = (INIT_DELAY > 0) ? c_st_fill : c_st_run;

    logic [WIDTH-1:0] r_chain [MAX_DELAY];
    logic [DW-1:0]    r_cur;
    logic [DW-1:0]    r_fill;
    logic [DW-1:0]    r_hold;
    logic [1:0]       r_state;
    logic             r_err;

    logic             w_accept;
    logic             w_clamp;
    logic [DW-1:0]    w_new;
    logic [DW-1:0]    w_cur_nxt;
    logic [DW-1:0]    w_fill_nxt;
    logic [DW-1:0]    w_hold_nxt;
    logic [1:0]       w_state_nxt;
    logic             w_cfg_ready;
    logic [WIDTH-1:0] w_tap;

    // Chain carries no reset: history validity is tracked by r_fill instead
    always_ff @(posedge clk) begin
        if (bus.ena) begin
            r_chain[0] <= bus.data;
            for (int j = 1; j < MAX_DELAY; j++) begin
                r_chain[j] <= r_chain[j-1];
            end
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur   <= c_init_delay;
            r_fill  <= '0;
            r_hold  <= '0;
            r_state <= c_st_init;
            r_err   <= 1'b0;
        end else begin
            r_cur   <= w_cur_nxt;
            r_fill  <= w_fill_nxt;
            r_hold  <= w_hold_nxt;
            r_state <= w_state_nxt;
            r_err   <= w_accept && w_clamp;
        end
    end

    // ---------------- next-state logic ----------------
    // The state is registered alongside the counters and is decoded from
    // their next values, so it always agrees with the counters it reflects.
    always_comb begin
        w_accept = bus.cfg_valid && w_cfg_ready;
        w_clamp  = (bus.cfg_delay > c_max_delay);
        w_new    = w_clamp ? c_max_delay : bus.cfg_delay;

        w_cur_nxt = w_accept ? w_new : r_cur;

        w_fill_nxt = r_fill;
        if (bus.ena && (r_fill != c_max_delay)) begin
            w_fill_nxt = r_fill + DW'(1);
        end

        // A freshly loaded hold value overrides the decrement, so an ena
        // in the accept cycle is not charged against the new hold.
        w_hold_nxt = r_hold;
        if (bus.ena && (r_hold != '0)) begin
            w_hold_nxt = r_hold - DW'(1);
        end
        if (w_accept && (w_new > r_cur)) begin
            w_hold_nxt = w_new - r_cur;
        end

        // Flush wins over counting and hold loading; the new delay still lands
        if (bus.flush) begin
            w_fill_nxt = '0;
            w_hold_nxt = '0;
        end

        if (w_hold_nxt != '0) begin
            w_state_nxt = c_st_hold;
        end else if (w_fill_nxt < w_cur_nxt) begin
            w_state_nxt = c_st_fill;
        end else begin
            w_state_nxt = c_st_run;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_cfg_ready = (r_state != c_st_hold);

        w_tap = bus.data;
        for (int j = 0; j < MAX_DELAY; j++) begin
            if (r_cur == DW'(j + 1)) begin
                w_tap = r_chain[j];
            end
        end

        bus.cfg_ready = w_cfg_ready;
        bus.cfg_err   = r_err;
        bus.delay     = w_tap;
        bus.out_valid = bus.ena && !rst && (r_state == c_st_run);
        bus.cur_delay = r_cur;
        bus.busy      = (r_state != c_st_run);
    end

endmodule

`default_nettype wire

// File: tb/tb_delay_ctrl.sv
// ============================================================================
//  Module      : tb_delay_ctrl
//  Description : Self-checking bench for delay_ctrl (WIDTH=16, MAX_DELAY=8,
//                INIT_DELAY=3). A sample-index model tracks the stream and
//                is compared every cycle; directed steps pin key values.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_delay_ctrl;
    localparam int WIDTH      = 16;
    localparam int MAX_DELAY  = 8;
    localparam int INIT_DELAY = 3;
    localparam int DW         = $clog2(MAX_DELAY + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    delay_ctrl_if #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) bus ();

    delay_ctrl #(
        .WIDTH     (WIDTH),
        .MAX_DELAY (MAX_DELAY),
        .INIT_DELAY(INIT_DELAY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: every ena sample ever presented is kept in hist. A sample is
    // valid when at least cur samples arrived since the last flush/reset
    // (epoch) and the sample index has passed the suppression point.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] hist[$];
    int  m_epoch = 0;
    int  m_supp  = 0;
    int  m_cur   = INIT_DELAY;
    bit  m_err   = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                int  n;
                bit  filled;
                n      = hist.size();
                filled = ((n - m_epoch) >= m_cur) && (n >= m_supp);
                chk("m_out_valid", int'(bus.out_valid), int'(bus.ena && filled));
                chk("m_busy",      int'(bus.busy),      int'(!filled));
                chk("m_cfg_ready", int'(bus.cfg_ready), int'(n >= m_supp));
                chk("m_cur_delay", int'(bus.cur_delay), m_cur);
                chk("m_cfg_err",   int'(bus.cfg_err),   int'(m_err));
                if (m_cur == 0)
                    chk("m_delay_pass", int'(bus.delay), int'(bus.data));
                else if (n >= m_cur)
                    chk("m_delay_tap", int'(bus.delay), int'(hist[n - m_cur]));
            end
            @(posedge clk);
            begin
                int n_after;
                int req;
                int nw;
                bit acc;
                n_after = hist.size() + (bus.ena ? 1 : 0);
                if (rst) begin
                    m_epoch = n_after;
                    m_supp  = 0;
                    m_cur   = INIT_DELAY;
                    m_err   = 1'b0;
                end else begin
                    acc   = bus.cfg_valid && (hist.size() >= m_supp);
                    req   = int'(bus.cfg_delay);
                    nw    = (req > MAX_DELAY) ? MAX_DELAY : req;
                    m_err = acc && (req > MAX_DELAY);
                    if (acc) begin
                        if (nw > m_cur) m_supp = n_after + (nw - m_cur);
                        m_cur = nw;
                    end
                    if (bus.flush) begin
                        m_supp  = 0;
                        m_epoch = n_after;
                    end
                end
                if (bus.ena) hist.push_back(bus.data);
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    int nextd = 1;

    task automatic step(input bit e, input bit f, input bit cv, input int cd);
        @(posedge clk);
        #1;
        bus.ena       = e;
        bus.flush     = f;
        bus.cfg_valid = cv;
        bus.cfg_delay = DW'(cd);
        if (e) begin
            bus.data = WIDTH'(nextd);
            nextd++;
        end else begin
            bus.data = 16'hBEEF;
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        int s;
        int f;
        bus.ena       = 1'b0;
        bus.data      = '0;
        bus.flush     = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_delay = '0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_cur_delay", int'(bus.cur_delay), 3);
        chk("rst_cfg_ready", int'(bus.cfg_ready), 1);
        chk("rst_cfg_err",   int'(bus.cfg_err),   0);
        chk("rst_busy",      int'(bus.busy),      1);
        chk("rst_out_valid", int'(bus.out_valid), 0);

        // Startup at INIT_DELAY=3
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 0, 0);
            if (i <= 3) chk("start_invalid", int'(bus.out_valid), 0);
        end
        chk("start_delay", int'(bus.delay),     1);
        chk("start_valid", int'(bus.out_valid), 1);
        chk("start_busy",  int'(bus.busy),      0);
        repeat (6) step(1, 0, 0, 0);

        // Decrease 3 -> 2, then run
        step(1, 0, 1, 2);
        repeat (4) step(1, 0, 0, 0);

        // Increase 2 -> 5
        step(1, 0, 1, 5);
        s = nextd - 1;
        chk("inc_last", int'(bus.delay), s - 2);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0);
            chk("inc_ready_low", int'(bus.cfg_ready), 0);
            chk("inc_bubble",    int'(bus.out_valid), 0);
        end
        step(1, 0, 0, 0);
        chk("inc_resume_val",   int'(bus.delay),     s - 1);
        chk("inc_resume_valid", int'(bus.out_valid), 1);
        repeat (2) step(1, 0, 0, 0);

        // Decrease 5 -> 2
        step(1, 0, 1, 2);
        s = nextd - 1;
        chk("dec_before", int'(bus.delay), s - 5);
        step(1, 0, 0, 0);
        chk("dec_jump",  int'(bus.delay),     s - 1);
        chk("dec_valid", int'(bus.out_valid), 1);
        chk("dec_ready", int'(bus.cfg_ready), 1);

        // ena gaps during FILL after a flush (cur=2)
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("gap_busy0", int'(bus.busy), 1);
        step(1, 0, 0, 0);
        f = nextd - 1;
        chk("gap_fill1", int'(bus.out_valid), 0);
        step(0, 0, 0, 0);
        chk("gap_busy1", int'(bus.busy), 1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("gap_filled", int'(bus.busy), 0);
        step(1, 0, 0, 0);
        chk("gap_first_val", int'(bus.delay),     f);
        chk("gap_first_vld", int'(bus.out_valid), 1);

        // Increase 2 -> 4 with ena gaps in HOLD
        step(1, 0, 1, 4);
        step(0, 0, 0, 0);
        chk("gh_ready0", int'(bus.cfg_ready), 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("gh_ready1", int'(bus.cfg_ready), 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("gh_ready2", int'(bus.cfg_ready), 1);

        // Clamp 12 -> 8
        step(1, 0, 1, 12);
        step(1, 0, 0, 0);
        chk("clamp_cur", int'(bus.cur_delay), 8);
        chk("clamp_err", int'(bus.cfg_err),   1);
        step(1, 0, 0, 0);
        chk("clamp_err_once", int'(bus.cfg_err), 0);
        repeat (4) step(1, 0, 0, 0);

        // Back to 4, then flush together with cfg 6
        step(1, 0, 1, 4);
        repeat (8) step(1, 0, 0, 0);
        step(1, 1, 1, 6);
        f = nextd;
        for (int i = 1; i <= 7; i++) begin
            step(1, 0, 0, 0);
            if (i == 1) begin
                chk("fc_cur",   int'(bus.cur_delay), 6);
                chk("fc_ready", int'(bus.cfg_ready), 1);
                chk("fc_busy",  int'(bus.busy),      1);
            end
            if (i <= 6) chk("fc_fill", int'(bus.out_valid), 0);
        end
        chk("fc_first_val", int'(bus.delay),     f);
        chk("fc_first_vld", int'(bus.out_valid), 1);

        // Pass-through at delay 0
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        chk("pass_val", int'(bus.delay), nextd - 1);
        chk("pass_vld", int'(bus.out_valid), 1);

        // Request held during HOLD, then reset mid-operation
        step(1, 0, 1, 3);
        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        chk("held_cur", int'(bus.cur_delay), 3);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.ena       = 1'b0;
        bus.cfg_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst_cur",   int'(bus.cur_delay), 3);
        chk("mrst_busy",  int'(bus.busy),      1);
        chk("mrst_ready", int'(bus.cfg_ready), 1);
        repeat (5) step(1, 0, 0, 0);

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
